// File: rtl/sram_bist.sv
// sram_bist: March-test initiator for the single-port sram block.
// Runs a four-element March sequence (W P; R P / W ~P ascending;
// R ~P / W P descending; R P ascending) against the sram's registered dout.
// It reports pass/fail, the first failing address and data, and a saturating
// mismatch count.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start_i             level; only sampled while idle
//   pattern_i           background word P, captured when start is accepted
//   busy_o              test in progress (7*DATA_DEPTH cycles)
//   done_o              one-cycle pulse at completion
//   pass_o              last completed run had zero mismatches
//   fail_addr_o         address of the first mismatch of the last run
//   fail_data_o         data read at the first mismatch
//   err_count_o         mismatch count, saturating at all-ones
//   sram_cs_n_o         sram chip select, active low (registered)
//   sram_w_en_o         sram write enable (registered)
//   sram_addr_o         sram address (registered)
//   sram_din_o          sram write data (registered)
//   sram_dout_i         sram read data, valid the cycle after a read issue
//
// state | meaning
// IDLE  | waiting for start, sram deselected
// M0_W  | write P, ascending
// M1_R  | read issue, ascending
// M1_W  | compare dout vs P, write ~P at the same address
// M2_R  | read issue, descending
// M2_W  | compare dout vs ~P, write P at the same address
// M3_R  | read issue, ascending
// M3_C  | compare dout vs P, sram deselected
// DONE  | one-cycle completion, pass latched
//
// DATA_DEPTH must not exceed 2**ADDR_DEPTH.

module sram_bist #(
   parameter int ADDR_DEPTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 16,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] pattern_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [ADDR_DEPTH-1:0] fail_addr_o,
   output logic [DATA_WIDTH-1:0] fail_data_o,
   output logic [ERR_WIDTH-1:0]  err_count_o,
   output logic                  sram_cs_n_o,
   output logic                  sram_w_en_o,
   output logic [ADDR_DEPTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_din_o,
   input  logic [DATA_WIDTH-1:0] sram_dout_i
);

   typedef enum logic [3:0] {
      IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_C, DONE
   } state_t;

   localparam logic [ADDR_DEPTH-1:0] ADDR_LAST = ADDR_DEPTH'(DATA_DEPTH - 1);
   localparam logic [ADDR_DEPTH-1:0] ADDR_ONE  = ADDR_DEPTH'(1);
   localparam logic [ERR_WIDTH-1:0]  ERR_ONE   = ERR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_DEPTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] pat_q, pat_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [ADDR_DEPTH-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
   logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
   logic                  sram_cs_n_q, sram_cs_n_d;
   logic                  sram_w_en_q, sram_w_en_d;
   logic [ADDR_DEPTH-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0] sram_din_q, sram_din_d;

   logic                  cmp_en;
   logic [DATA_WIDTH-1:0] cmp_exp;
   logic                  mismatch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         pat_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         err_count_q <= '0;
         sram_cs_n_q <= 1'b1;
         sram_w_en_q <= 1'b0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pat_q       <= pat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         err_count_q <= err_count_d;
         sram_cs_n_q <= sram_cs_n_d;
         sram_w_en_q <= sram_w_en_d;
         sram_addr_q <= sram_addr_d;
         sram_din_q  <= sram_din_d;
      end
   end

   // The data being checked in a compare state was issued by the read state
   // one cycle earlier, so dout is compared directly without extra staging.
   always_comb begin
      cmp_en  = 1'b0;
      cmp_exp = pat_q;
      case (state_q)
         M1_W:    begin cmp_en = 1'b1; cmp_exp = pat_q;  end
         M2_W:    begin cmp_en = 1'b1; cmp_exp = ~pat_q; end
         M3_C:    begin cmp_en = 1'b1; cmp_exp = pat_q;  end
         default: ;
      endcase
      mismatch = cmp_en && (sram_dout_i != cmp_exp);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pat_d       = pat_q;
      pass_d      = pass_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      err_count_d = err_count_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d     = M0_W;
               addr_d      = '0;
               pat_d       = pattern_i;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
               err_count_d = '0;
            end
         end
         M0_W: begin
            if (addr_q == ADDR_LAST) begin
               state_d = M1_R;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
            end
         end
         M1_R: state_d = M1_W;
         M1_W: begin
            if (addr_q == ADDR_LAST) begin
               state_d = M2_R;
            end else begin
               state_d = M1_R;
               addr_d  = addr_q + ADDR_ONE;
            end
         end
         M2_R: state_d = M2_W;
         M2_W: begin
            if (addr_q == '0) begin
               state_d = M3_R;
            end else begin
               state_d = M2_R;
               addr_d  = addr_q - ADDR_ONE;
            end
         end
         M3_R: state_d = M3_C;
         M3_C: begin
            if (addr_q == ADDR_LAST) begin
               state_d = DONE;
               addr_d  = '0;
            end else begin
               state_d = M3_R;
               addr_d  = addr_q + ADDR_ONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // err_count_q is cleared at start, so zero means no mismatch yet.
      if (mismatch) begin
         if (err_count_q == '0) begin
            fail_addr_d = addr_q;
            fail_data_d = sram_dout_i;
         end
         if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_ONE;
         end
      end

      // Status uses the count including the final M3_C compare.
      if (state_d == DONE) begin
         pass_d = (err_count_d == '0);
      end
   end

   // Pin and handshake registers are loaded from the next state so that
   // each state's pin values appear in the same cycle the state is active.
   always_comb begin
      busy_d      = (state_d != IDLE) && (state_d != DONE);
      done_d      = (state_d == DONE);
      sram_cs_n_d = 1'b1;
      sram_w_en_d = 1'b0;
      sram_addr_d = addr_d;
      sram_din_d  = '0;
      case (state_d)
         M0_W:    begin sram_cs_n_d = 1'b0; sram_w_en_d = 1'b1; sram_din_d = pat_d;  end
         M1_R:    begin sram_cs_n_d = 1'b0;                     sram_din_d = ~pat_d; end
         M1_W:    begin sram_cs_n_d = 1'b0; sram_w_en_d = 1'b1; sram_din_d = ~pat_d; end
         M2_R:    begin sram_cs_n_d = 1'b0;                     sram_din_d = pat_d;  end
         M2_W:    begin sram_cs_n_d = 1'b0; sram_w_en_d = 1'b1; sram_din_d = pat_d;  end
         M3_R:    begin sram_cs_n_d = 1'b0;                     sram_din_d = pat_d;  end
         default: ;
      endcase
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_data_o = fail_data_q;
   assign err_count_o = err_count_q;
   assign sram_cs_n_o = sram_cs_n_q;
   assign sram_w_en_o = sram_w_en_q;
   assign sram_addr_o = sram_addr_q;
   assign sram_din_o  = sram_din_q;

endmodule
